imem_port_scheduler: RTL and testbench
======================================

Name: imem_port_scheduler

Overview:
- Shares the single-port instruction memory between the host program loader (writes) and the pipeline fetch stage (reads).
- Sits between the host/PCIe frontend, the instruction BRAM, and the fetch-stage interface (addr/valid out, data/valid/addr in, ready).
- Sequences ownership with a drain-then-grant FSM.
- Tracks in-flight BRAM reads so returned data carries its address and branch flushes discard stale fetches.

Parameters:
- IMEM_ADDR_WIDTH, 10, instruction memory address width (depth = 2^IMEM_ADDR_WIDTH).
- INSTR_WIDTH, 64, instruction word width.
- RD_LAT, 2, BRAM read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_busy  in  1  pipeline executing a program (inverse of softmc_end)
- host_load_req  in  1  host requests memory ownership for program load; level
- host_load_gnt  out  1  host owns memory
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  host write accepted
- host_wr_addr  in  IMEM_ADDR_WIDTH  write address
- host_wr_data  in  INSTR_WIDTH  write data
- load_count  out  IMEM_ADDR_WIDTH+1  writes accepted in current/last load session
- fe_valid  in  1  fetch read request
- fe_addr  in  IMEM_ADDR_WIDTH  fetch address
- fe_ready  out  1  fetch request accepted
- fe_flush  in  1  branch resolved; discard in-flight reads
- fe_rvalid  out  1  read data valid
- fe_raddr  out  IMEM_ADDR_WIDTH  address of returned word
- fe_rdata  out  INSTR_WIDTH  returned word
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  IMEM_ADDR_WIDTH  BRAM address
- mem_wdata  out  INSTR_WIDTH  BRAM write data
- mem_rdata  in  INSTR_WIDTH  BRAM read data, valid RD_LAT cycles after mem_en with !mem_we

Behaviour:
- Reset: state=S_FETCH.
  - host_load_gnt, host_wr_ready, fe_ready, fe_rvalid, mem_en and mem_we = 0.
  - load_count, fe_raddr, mem_addr and mem_wdata = 0.
  - Tracker is empty.
- The memory port is combinational from the current state and requests.
  - At most one access per cycle.
  - mem_addr/mem_wdata hold their last value when mem_en=0.
- S_FETCH:
  - fe_ready=1.
  - fe_valid&fe_ready drives mem_en=1, mem_we=0, mem_addr=fe_addr and pushes {1, fe_addr} into the tracker.
  - host_wr_ready=0.
  - host_load_req & !pipe_busy goes to S_DRAIN.
  - host_load_req while pipe_busy waits in S_FETCH; there is no preemption.
- S_DRAIN:
  - fe_ready=0.
  - Goes to S_LOAD when the tracker has no valid entries (the last return has been delivered).
  - If host_load_req drops during drain, return to S_FETCH.
- S_LOAD:
  - host_load_gnt=1 (registered; asserted the cycle after entry).
  - On entry, load_count clears to 0.
  - host_wr_ready=1; each host_wr_valid drives mem_en=1, mem_we=1, mem_addr=host_wr_addr, mem_wdata=host_wr_data, and increments load_count, saturating at 2^IMEM_ADDR_WIDTH.
  - fe_ready=0.
  - host_load_req low goes to S_FETCH; host_load_gnt drops the same edge.
  - A write presented in the cycle host_load_req falls is still accepted.
- Tracker:
  - RD_LAT-deep shift register of {valid, addr}.
  - At stage RD_LAT: fe_rvalid=valid, fe_raddr=addr, fe_rdata=mem_rdata.
  - Latency from accept to fe_rvalid is exactly RD_LAT cycles.
  - Back-to-back accepts give back-to-back returns in order.
- Flush:
  - fe_flush clears every tracker valid bit at the edge, so entries due in later cycles never appear.
  - An entry at the output in the flush cycle is suppressed (fe_rvalid forced 0 combinationally).
  - A request accepted in the flush cycle is kept, since it is the branch target.
- pipe_busy rising while in S_DRAIN/S_LOAD is ignored; ownership stays with the host until it releases.
- rst_n low mid-load or mid-fetch: all state is cleared immediately. A partially written program is not rolled back, and load_count reads 0.

Decomposition:
- Shared package/header holds:
  - state encoding S_FETCH=2'd0, S_DRAIN=2'd1, S_LOAD=2'd2;
  - IMEM_ADDR_WIDTH and INSTR_WIDTH defaults (reuse the existing `IMEM_ADDR_WIDTH/`INSTR_WIDTH defines).
- One sub-module: imem_read_tracker, the RD_LAT shift register with flush and an any-valid output used by the drain condition.

Test Plan:
- Reset, then fe_valid on addresses 0,1,2 in consecutive cycles with RD_LAT=2 -> fe_rvalid high cycles 2,3,4 after the first accept, with fe_raddr 0,1,2 and fe_rdata matching preloaded BRAM.
- Issue fetch at addr 5, then fe_flush one cycle later with a new request at 40 in the flush cycle -> no return for 5; addr 40 returns RD_LAT cycles after its accept.
- host_load_req with pipe_busy=1 for 10 cycles -> host_load_gnt stays 0 and fetches continue. Drop pipe_busy with one read in flight -> S_DRAIN, the read is delivered, then host_load_gnt=1.
- In S_LOAD, write 8 words to addresses 0..7, one with host_wr_valid gap -> mem_we pulses 8 times, load_count=8, and fe_ready=0 throughout.
- Release host_load_req, then fetch 0..7 -> data equals the written words.
- Assert rst_n=0 in S_LOAD after 3 writes -> all outputs return to reset values asynchronously, state is S_FETCH, and load_count=0.

Source files
------------

// File: rtl/imem_port_scheduler_pkg.sv
// Shared types and defaults for the instruction-memory port scheduler.
// Width defaults come from the project-wide IMEM/INSTR defines when present.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 64
`endif

package imem_port_scheduler_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } state_e;

  localparam int IMEM_ADDR_WIDTH_DEF = `IMEM_ADDR_WIDTH;
  localparam int INSTR_WIDTH_DEF     = `INSTR_WIDTH;
  localparam int RD_LAT_DEF          = 2;

endpackage

// File: rtl/imem_read_tracker.sv
// Shift register that follows each BRAM read for RD_LAT cycles so the returned
// word carries its address; a flush kills everything older than this cycle.
module imem_read_tracker
  import imem_port_scheduler_pkg::*;
#(
  parameter int AW     = IMEM_ADDR_WIDTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          o_rvalid,
  output logic [AW-1:0] o_raddr,
  output logic          o_any_valid
);

  logic [RD_LAT-1:0] r_vld;
  logic [AW-1:0]     r_addr [RD_LAT];

  // Stage 0 takes the new request (kept across a flush: it is the branch target).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_push;
      if (i_push) begin
        r_addr[0] <= i_addr;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1] & ~i_flush;
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_rvalid    = r_vld[RD_LAT-1] & ~i_flush;
  assign o_raddr     = r_addr[RD_LAT-1];
  assign o_any_valid = |r_vld;

endmodule

// File: rtl/imem_port_scheduler.sv
// Arbitrates the single-port instruction BRAM between host program loads and
// pipeline fetches using a drain-then-grant ownership FSM.
module imem_port_scheduler
  import imem_port_scheduler_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH     = INSTR_WIDTH_DEF,
  parameter int RD_LAT          = RD_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_busy,
  input  logic                       host_load_req,
  output logic                       host_load_gnt,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic [IMEM_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [INSTR_WIDTH-1:0]     host_wr_data,
  output logic [IMEM_ADDR_WIDTH:0]   load_count,
  input  logic                       fe_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] fe_addr,
  output logic                       fe_ready,
  input  logic                       fe_flush,
  output logic                       fe_rvalid,
  output logic [IMEM_ADDR_WIDTH-1:0] fe_raddr,
  output logic [INSTR_WIDTH-1:0]     fe_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]     mem_wdata,
  input  logic [INSTR_WIDTH-1:0]     mem_rdata
);

  localparam logic [IMEM_ADDR_WIDTH:0] CNT_MAX = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};
  localparam logic [IMEM_ADDR_WIDTH:0] CNT_ONE = {{IMEM_ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                     r_state;
  state_e                     w_next;
  logic                       r_out_en;
  logic                       r_gnt;
  logic [IMEM_ADDR_WIDTH:0]   r_cnt;
  logic [IMEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [INSTR_WIDTH-1:0]     r_mem_wdata;

  logic                       w_fe_ready;
  logic                       w_wr_ready;
  logic                       w_push;
  logic                       w_any_valid;
  logic                       w_mem_en;
  logic                       w_mem_we;
  logic [IMEM_ADDR_WIDTH-1:0] w_mem_addr;
  logic [INSTR_WIDTH-1:0]     w_mem_wdata;

  // Ownership sequencing: fetch may not be preempted, load waits for an empty tracker.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (host_load_req && !pipe_busy) w_next = S_DRAIN;
        else                             w_next = S_FETCH;
      end
      S_DRAIN: begin
        if (!host_load_req)    w_next = S_FETCH;
        else if (!w_any_valid) w_next = S_LOAD;
        else                   w_next = S_DRAIN;
      end
      S_LOAD: begin
        if (!host_load_req) w_next = S_FETCH;
        else                w_next = S_LOAD;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Memory port mux; address/data fall back to the last driven values when idle.
  always_comb begin
    w_fe_ready  = 1'b0;
    w_wr_ready  = 1'b0;
    w_push      = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    case (r_state)
      S_FETCH: begin
        w_fe_ready = r_out_en;
        if (fe_valid && r_out_en) begin
          w_push     = 1'b1;
          w_mem_en   = 1'b1;
          w_mem_addr = fe_addr;
        end else begin
          w_push = 1'b0;
        end
      end
      S_LOAD: begin
        w_wr_ready = 1'b1;
        if (host_wr_valid) begin
          w_mem_en    = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = host_wr_addr;
          w_mem_wdata = host_wr_data;
        end else begin
          w_mem_we = 1'b0;
        end
      end
      default: begin
        w_fe_ready = 1'b0;
      end
    endcase
  end

  // State register; r_out_en keeps the ready outputs low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_out_en <= 1'b1;
    end
  end

  // Grant rises the cycle after entering S_LOAD and falls on the leaving edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_gnt <= (r_state == S_LOAD) && (w_next == S_LOAD);
      if ((r_state != S_LOAD) && (w_next == S_LOAD)) begin
        r_cnt <= '0;
      end else if (w_mem_we && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Hold registers for the memory address/data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_mem_en) r_mem_addr  <= w_mem_addr;
      if (w_mem_we) r_mem_wdata <= w_mem_wdata;
    end
  end

  imem_read_tracker #(
    .AW     (IMEM_ADDR_WIDTH),
    .RD_LAT (RD_LAT)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_addr      (fe_addr),
    .i_flush     (fe_flush),
    .o_rvalid    (fe_rvalid),
    .o_raddr     (fe_raddr),
    .o_any_valid (w_any_valid)
  );

  assign host_load_gnt = r_gnt;
  assign host_wr_ready = w_wr_ready;
  assign load_count    = r_cnt;
  assign fe_ready      = w_fe_ready;
  assign fe_rdata      = mem_rdata;
  assign mem_en        = w_mem_en;
  assign mem_we        = w_mem_we;
  assign mem_addr      = w_mem_addr;
  assign mem_wdata     = w_mem_wdata;

endmodule

// File: tb/tb_imem_port_scheduler.sv
// Directed bench for imem_port_scheduler with a 2-cycle BRAM model.
module tb_imem_port_scheduler;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_busy, host_load_req, host_load_gnt;
  logic          host_wr_valid, host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic [AW:0]   load_count;
  logic          fe_valid, fe_ready, fe_flush, fe_rvalid;
  logic [AW-1:0] fe_addr, fe_raddr;
  logic [DW-1:0] fe_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  imem_port_scheduler #(
    .IMEM_ADDR_WIDTH (AW),
    .INSTR_WIDTH     (DW),
    .RD_LAT          (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_busy     (pipe_busy),
    .host_load_req (host_load_req),
    .host_load_gnt (host_load_gnt),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .load_count    (load_count),
    .fe_valid      (fe_valid),
    .fe_addr       (fe_addr),
    .fe_ready      (fe_ready),
    .fe_flush      (fe_flush),
    .fe_rvalid     (fe_rvalid),
    .fe_raddr      (fe_raddr),
    .fe_rdata      (fe_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [63:0] pat(input int a);
    logic [31:0] v;
    v = 32'(a);
    return {32'hC0DE_0000 + v, 32'h1234_5678 ^ v};
  endfunction

  function automatic logic [63:0] wd(input int a);
    logic [31:0] v;
    v = 32'(a);
    return {32'hFEED_0000 + v, 32'hBEEF_0000 + v};
  endfunction

  // BRAM model: unwritten locations read back the preload pattern.
  logic [DW-1:0] mem_model [1024];
  bit            wr_flag   [1024];
  logic [DW-1:0] rd_p1, rd_p2;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
      wr_flag[mem_addr]   <= 1'b1;
    end
    if (mem_en && !mem_we) rd_p1 <= wr_flag[mem_addr] ? mem_model[mem_addr] : pat(int'(mem_addr));
    rd_p2 <= rd_p1;
  end
  assign mem_rdata = rd_p2;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string p);
    chk_eq({p, "_gnt"},    64'(host_load_gnt), 64'd0);
    chk_eq({p, "_wrrdy"},  64'(host_wr_ready), 64'd0);
    chk_eq({p, "_ferdy"},  64'(fe_ready),      64'd0);
    chk_eq({p, "_rvalid"}, 64'(fe_rvalid),     64'd0);
    chk_eq({p, "_men"},    64'(mem_en),        64'd0);
    chk_eq({p, "_mwe"},    64'(mem_we),        64'd0);
    chk_eq({p, "_lcnt"},   64'(load_count),    64'd0);
    chk_eq({p, "_raddr"},  64'(fe_raddr),      64'd0);
    chk_eq({p, "_maddr"},  64'(mem_addr),      64'd0);
    chk_eq({p, "_mwdata"}, mem_wdata,          64'd0);
  endtask

  int exp_rv  [6] = '{1, 1, 1, 0, 0, 0};
  int exp_ra  [3] = '{108, 109, 3};
  int exp_fr  [6] = '{1, 0, 0, 0, 0, 0};
  int exp_gnt [6] = '{0, 0, 0, 0, 0, 1};
  int exp_wr  [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int we_cnt;
    int idx;
    int k;
    rst_n = 1'b0; pipe_busy = 1'b0; host_load_req = 1'b0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    fe_valid = 1'b0; fe_addr = '0; fe_flush = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Back-to-back fetches 0,1,2
    for (int c = 0; c < 6; c++) begin
      fe_valid = (c < 3);
      fe_addr  = AW'(c);
      @(negedge clk);
      if (c < 3) begin
        chk_eq($sformatf("t1_ferdy%0d", c), 64'(fe_ready), 64'd1);
        chk_eq($sformatf("t1_maddr%0d", c), 64'(mem_addr), 64'(c));
      end
      chk_eq($sformatf("t1_rvalid%0d", c), 64'(fe_rvalid), 64'((c >= 2) && (c <= 4)));
      if ((c >= 2) && (c <= 4)) begin
        chk_eq($sformatf("t1_raddr%0d", c), 64'(fe_raddr), 64'(c - 2));
        chk_eq($sformatf("t1_rdata%0d", c), fe_rdata, pat(c - 2));
      end
      next_cyc();
    end

    // Flush one cycle after fetching 5, branch target 40 in the flush cycle
    for (int c = 0; c < 5; c++) begin
      fe_valid = (c < 2);
      fe_addr  = (c == 0) ? AW'(5) : AW'(40);
      fe_flush = (c == 1);
      @(negedge clk);
      if (c == 1) chk_eq("t2_men_flush", 64'(mem_en), 64'd1);
      chk_eq($sformatf("t2_rvalid%0d", c), 64'(fe_rvalid), 64'(c == 3));
      if (c == 3) begin
        chk_eq("t2_raddr", 64'(fe_raddr), 64'd40);
        chk_eq("t2_rdata", fe_rdata, pat(40));
      end
      next_cyc();
    end

    // Flush in the return cycle suppresses the output
    for (int c = 0; c < 4; c++) begin
      fe_valid = (c == 0);
      fe_addr  = AW'(7);
      fe_flush = (c == 2);
      @(negedge clk);
      if (c >= 2) chk_eq($sformatf("t2b_rvalid%0d", c), 64'(fe_rvalid), 64'd0);
      next_cyc();
    end
    fe_flush = 1'b0;

    // Load request while pipeline busy: no grant, fetch continues
    pipe_busy = 1'b1;
    host_load_req = 1'b1;
    for (int b = 0; b < 10; b++) begin
      fe_valid = 1'b1;
      fe_addr  = AW'(100 + b);
      @(negedge clk);
      chk_eq($sformatf("t3_gnt%0d", b), 64'(host_load_gnt), 64'd0);
      chk_eq($sformatf("t3_ferdy%0d", b), 64'(fe_ready), 64'd1);
      chk_eq($sformatf("t3_rvalid%0d", b), 64'(fe_rvalid), 64'(b >= 2));
      if (b >= 2) chk_eq($sformatf("t3_raddr%0d", b), 64'(fe_raddr), 64'(98 + b));
      next_cyc();
    end

    // Drop busy with reads in flight: drain, deliver, then grant
    pipe_busy = 1'b0;
    for (int d = 0; d < 6; d++) begin
      fe_valid = (d == 0);
      fe_addr  = AW'(3);
      @(negedge clk);
      chk_eq($sformatf("t3d_ferdy%0d", d), 64'(fe_ready), 64'(exp_fr[d]));
      chk_eq($sformatf("t3d_rvalid%0d", d), 64'(fe_rvalid), 64'(exp_rv[d]));
      chk_eq($sformatf("t3d_gnt%0d", d), 64'(host_load_gnt), 64'(exp_gnt[d]));
      chk_eq($sformatf("t3d_wrrdy%0d", d), 64'(host_wr_ready), 64'(exp_wr[d]));
      if (d < 3) chk_eq($sformatf("t3d_raddr%0d", d), 64'(fe_raddr), 64'(exp_ra[d]));
      if (d == 2) chk_eq("t3d_rdata", fe_rdata, pat(3));
      next_cyc();
    end

    // Eight writes to 0..7 with one gap; fetch requests must be refused
    we_cnt = 0;
    idx = 0;
    for (int w = 0; w < 9; w++) begin
      fe_valid      = 1'b1;
      fe_addr       = AW'(85);
      host_wr_valid = (w != 3);
      host_wr_addr  = AW'(idx);
      host_wr_data  = wd(idx);
      @(negedge clk);
      we_cnt += int'(mem_we);
      chk_eq($sformatf("t4_mwe%0d", w), 64'(mem_we), 64'(w != 3));
      chk_eq($sformatf("t4_ferdy%0d", w), 64'(fe_ready), 64'd0);
      chk_eq($sformatf("t4_gnt%0d", w), 64'(host_load_gnt), 64'd1);
      if (w != 3) begin
        chk_eq($sformatf("t4_maddr%0d", w), 64'(mem_addr), 64'(idx));
        chk_eq($sformatf("t4_mwdata%0d", w), mem_wdata, wd(idx));
        idx++;
      end
      next_cyc();
    end
    host_wr_valid = 1'b0;
    fe_valid = 1'b0;
    @(negedge clk);
    chk_eq("t4_we_pulses", 64'(we_cnt), 64'd8);
    chk_eq("t4_lcnt", 64'(load_count), 64'd8);
    chk_eq("t4_men_idle", 64'(mem_en), 64'd0);
    chk_eq("t4_maddr_hold", 64'(mem_addr), 64'd7);
    chk_eq("t4_mwdata_hold", mem_wdata, wd(7));
    next_cyc();

    // Release with a write in the same cycle
    host_load_req = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_addr  = AW'(8);
    host_wr_data  = wd(8);
    @(negedge clk);
    chk_eq("t5_mwe_rel", 64'(mem_we), 64'd1);
    chk_eq("t5_wrrdy_rel", 64'(host_wr_ready), 64'd1);
    next_cyc();
    host_wr_valid = 1'b0;
    @(negedge clk);
    chk_eq("t5_gnt_off", 64'(host_load_gnt), 64'd0);
    chk_eq("t5_ferdy", 64'(fe_ready), 64'd1);
    chk_eq("t5_lcnt", 64'(load_count), 64'd9);
    next_cyc();

    // Read back the loaded program
    for (int c = 0; c < 11; c++) begin
      fe_valid = (c < 9);
      fe_addr  = AW'(c);
      @(negedge clk);
      chk_eq($sformatf("t5_rvalid%0d", c), 64'(fe_rvalid), 64'(c >= 2));
      if (c >= 2) begin
        chk_eq($sformatf("t5_raddr%0d", c), 64'(fe_raddr), 64'(c - 2));
        chk_eq($sformatf("t5_rdata%0d", c), fe_rdata, wd(c - 2));
      end
      next_cyc();
    end
    fe_valid = 1'b0;

    // New load session, reset after three writes
    host_load_req = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (host_load_gnt) break;
      next_cyc();
      k++;
    end
    chk_eq("t6_gnt", 64'(host_load_gnt), 64'd1);
    chk_eq("t6_lcnt_clr", 64'(load_count), 64'd0);
    next_cyc();
    for (int w = 0; w < 3; w++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = AW'(20 + w);
      host_wr_data  = wd(20 + w);
      next_cyc();
    end
    host_wr_valid = 1'b0;
    @(negedge clk);
    chk_eq("t6_lcnt3", 64'(load_count), 64'd3);
    next_cyc();
    host_wr_valid = 1'b1;
    host_wr_addr  = AW'(30);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6rst");
    host_wr_valid = 1'b0;
    host_load_req = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    @(negedge clk);
    chk_eq("t6_ferdy_after", 64'(fe_ready), 64'd1);
    chk_eq("t6_gnt_after", 64'(host_load_gnt), 64'd0);
    chk_eq("t6_lcnt_after", 64'(load_count), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
